// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard/forwarding unit.
package hazard_pkg;

  // Widest register address a scoreboard entry can carry; narrower
  // addresses are zero-extended into it.
  localparam int MAX_REG_AW = 8;

  // Forward code meaning "take the operand from the register file".
  localparam int FWD_RF = 0;

  typedef logic [MAX_REG_AW-1:0] sb_rd_t;

  // One in-flight instruction tracked after decode.
  typedef struct packed {
    logic   valid;
    sb_rd_t rd;
    logic   we;
    logic   is_load;
  } sb_entry_t;

  // Width of a forward select able to encode 0 (regfile) .. depth.
  function automatic int fwd_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/src_forward_select.sv
// Per-source operand match: finds the youngest in-flight writer of one
// source register, encodes its forward select and flags a load-use hazard
// when that writer is a load whose data is not yet forwardable.
module src_forward_select
  import hazard_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int LOAD_AVAIL = 2,
  parameter int REG_AW     = 4,
  parameter int FW         = 2
) (
  input  sb_entry_t [DEPTH-1:0] entries,
  input  logic [REG_AW-1:0]     src,
  input  logic                  use_src,
  output logic [FW-1:0]         fwd,
  output logic                  hazard
);

  logic [DEPTH-1:0] match;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match[gi] = entries[gi].valid & entries[gi].we & use_src &
                         (entries[gi].rd == sb_rd_t'(src));
    end
  endgenerate

  // Scan oldest to youngest so the lowest matching index is the one kept.
  always_comb begin
    fwd    = FW'(FWD_RF);
    hazard = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match[i]) begin
        fwd    = FW'(i + 1);
        hazard = entries[i].is_load && (i < LOAD_AVAIL);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding unit: a shift-register scoreboard of in-flight
// destinations drives fetch stall, decode flush, execute bubble and
// per-source forward selects, plus saturating stall/flush counters.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS   = 16,
  parameter int REG_AW     = $clog2(NUM_REGS),
  parameter int DEPTH      = 3,
  parameter int LOAD_AVAIL = 2,
  parameter int CNT_W      = 16,
  parameter int FW         = fwd_width(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                dec_valid,
  input  logic [REG_AW-1:0]   dec_rs1,
  input  logic [REG_AW-1:0]   dec_rs2,
  input  logic                dec_use_rs1,
  input  logic                dec_use_rs2,
  input  logic [REG_AW-1:0]   dec_rd,
  input  logic                dec_we,
  input  logic                dec_is_load,
  input  logic                branch_taken,
  output logic                stall_f,
  output logic                flush_d,
  output logic                bubble_e,
  output logic [FW-1:0]       fwd_a,
  output logic [FW-1:0]       fwd_b,
  output logic [NUM_REGS-1:0] busy,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  sb_entry_t [DEPTH-1:0] sb_reg;
  sb_entry_t             new_entry;
  logic                  hazard_a;
  logic                  hazard_b;
  logic                  hazard;
  logic                  issue;

  src_forward_select #(
    .DEPTH(DEPTH), .LOAD_AVAIL(LOAD_AVAIL), .REG_AW(REG_AW), .FW(FW)
  ) u_sel_a (
    .entries(sb_reg), .src(dec_rs1), .use_src(dec_use_rs1),
    .fwd(fwd_a), .hazard(hazard_a)
  );

  src_forward_select #(
    .DEPTH(DEPTH), .LOAD_AVAIL(LOAD_AVAIL), .REG_AW(REG_AW), .FW(FW)
  ) u_sel_b (
    .entries(sb_reg), .src(dec_rs2), .use_src(dec_use_rs2),
    .fwd(fwd_b), .hazard(hazard_b)
  );

  assign hazard = hazard_a | hazard_b;

  // Pipeline control: a taken branch overrides any pending load-use stall.
  always_comb begin
    stall_f  = 1'b0;
    flush_d  = 1'b0;
    bubble_e = 1'b0;
    if (branch_taken) begin
      flush_d  = 1'b1;
      bubble_e = 1'b1;
    end else if (hazard && dec_valid) begin
      stall_f  = 1'b1;
      bubble_e = 1'b1;
    end
  end

  assign issue = dec_valid & ~stall_f & ~branch_taken;

  // Entry entering execute: decode fields on issue, otherwise a bubble.
  always_comb begin
    new_entry = '0;
    if (issue) begin
      new_entry.valid   = 1'b1;
      new_entry.rd      = sb_rd_t'(dec_rd);
      new_entry.we      = dec_we;
      new_entry.is_load = dec_is_load;
    end
  end

  // Scoreboard shift toward writeback; the oldest entry falls off.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_reg <= '0;
    end else begin
      sb_reg[0] <= new_entry;
      for (int i = 1; i < DEPTH; i++) begin
        sb_reg[i] <= sb_reg[i-1];
      end
    end
  end

  // Pending-write bitmap derived from the registered scoreboard.
  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sb_reg[i].valid && sb_reg[i].we) begin
        busy[sb_reg[i].rd[REG_AW-1:0]] = 1'b1;
      end
    end
  end

  // Saturating event counters for stall and flush cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_f && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_d && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: default instance plus a deep,
// 4-bit-counter instance used to exercise counter saturation.
`timescale 1ns/1ps
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        dec_valid = 1'b0;
  logic [3:0]  dec_rs1 = '0, dec_rs2 = '0, dec_rd = '0;
  logic        dec_use_rs1 = 1'b0, dec_use_rs2 = 1'b0;
  logic        dec_we = 1'b0, dec_is_load = 1'b0, branch_taken = 1'b0;

  logic        stall_f, flush_d, bubble_e;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] busy, stall_cnt, flush_cnt;

  logic        stall_f2, flush_d2, bubble_e2;
  logic [4:0]  fwd_a2, fwd_b2;
  logic [15:0] busy2;
  logic [3:0]  stall_cnt2, flush_cnt2;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .dec_rd(dec_rd), .dec_we(dec_we), .dec_is_load(dec_is_load),
    .branch_taken(branch_taken),
    .stall_f(stall_f), .flush_d(flush_d), .bubble_e(bubble_e),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .busy(busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_scoreboard #(.DEPTH(24), .LOAD_AVAIL(22), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .dec_valid(dec_valid),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .dec_rd(dec_rd), .dec_we(dec_we), .dec_is_load(dec_is_load),
    .branch_taken(branch_taken),
    .stall_f(stall_f2), .flush_d(flush_d2), .bubble_e(bubble_e2),
    .fwd_a(fwd_a2), .fwd_b(fwd_b2), .busy(busy2),
    .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-14s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [3:0] rs1, input logic u1,
                       input logic [3:0] rs2, input logic u2,
                       input logic [3:0] rd, input logic we, input logic ld,
                       input logic br);
    dec_valid = v; dec_rs1 = rs1; dec_use_rs1 = u1;
    dec_rs2 = rs2; dec_use_rs2 = u2;
    dec_rd = rd; dec_we = we; dec_is_load = ld; branch_taken = br;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    // Reset state
    step(); step();
    chk("rst_stall", stall_f, 0);
    chk("rst_flush", flush_d, 0);
    chk("rst_bubble", bubble_e, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stallcnt", stall_cnt, 0);
    reset = 1'b1;
    step();

    // Back-to-back RAW: ALU result forwarded from execute, then memory, then writeback
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
    chk("raw_issue_stall", stall_f, 0);
    step();
    drive(1, 3, 1, 0, 0, 7, 1, 0, 0);
    chk("raw_fwd_a_ex", fwd_a, 1);
    chk("raw_stall", stall_f, 0);
    chk("raw_busy", busy, 16'h0008);
    step();
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0);
    chk("raw_fwd_a_mem", fwd_a, 2);
    chk("raw_busy2", busy, 16'h0088);
    step();
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0);
    chk("raw_fwd_a_wb", fwd_a, 3);
    step();
    idle(3);
    chk("drain_busy", busy, 0);

    // Load-use: two bubbles then forward from writeback
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0);
    chk("ld_issue_stall", stall_f, 0);
    step();
    drive(1, 0, 0, 5, 1, 1, 1, 0, 0);
    chk("lu1_stall", stall_f, 1);
    chk("lu1_bubble", bubble_e, 1);
    chk("lu1_flush", flush_d, 0);
    step();
    chk("lu2_stall", stall_f, 1);
    chk("lu2_bubble", bubble_e, 1);
    step();
    chk("lu3_stall", stall_f, 0);
    chk("lu3_fwd_b", fwd_b, 3);
    chk("lu3_stallcnt", stall_cnt, 2);
    step();
    idle(3);

    // Youngest match wins over an older one
    drive(1, 0, 0, 0, 0, 4, 1, 0, 0);
    step();
    step();
    drive(1, 4, 1, 0, 0, 0, 0, 0, 0);
    chk("young_fwd_a", fwd_a, 1);
    step();
    idle(3);

    // Branch overrides load-use stall
    drive(1, 0, 0, 0, 0, 6, 1, 1, 0);
    step();
    drive(1, 6, 1, 0, 0, 0, 0, 0, 1);
    chk("br_busy", busy, 16'h0040);
    chk("br_flush", flush_d, 1);
    chk("br_bubble", bubble_e, 1);
    chk("br_stall", stall_f, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("br_flushcnt", flush_cnt, 1);
    chk("br_stallcnt", stall_cnt, 2);
    idle(3);

    // Reset asserted in the middle of a load-use stall
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0);
    step();
    drive(1, 0, 0, 5, 1, 0, 0, 0, 0);
    chk("mid_pre_stall", stall_f, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_stall", stall_f, 0);
    chk("mid_rst_bubble", bubble_e, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_stallcnt", stall_cnt, 0);
    chk("mid_rst_flushcnt", flush_cnt, 0);
    chk("mid_rst_fwd_b", fwd_b, 0);
    idle(1);
    reset = 1'b1;
    step();

    // Saturation on the deep 4-bit-counter instance
    drive(1, 0, 0, 0, 0, 9, 1, 1, 0);
    step();
    drive(1, 9, 1, 0, 0, 0, 0, 0, 0);
    chk("sat_stall_on", stall_f2, 1);
    for (int k = 0; k < 5; k++) step();
    chk("sat_cnt5", stall_cnt2, 5);
    for (int k = 0; k < 15; k++) step();
    chk("sat_still_stall", stall_f2, 1);
    chk("sat_cnt20", stall_cnt2, 15);
    chk("sat_dflt_cnt", stall_cnt, 2);
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding unit for the pipelined 16-bit CPU. It tracks destination registers of in-flight instructions in a DEPTH-entry scoreboard spanning execute through writeback. From that state it drives fetch stall, decode flush, execute bubble insertion and per-source operand forwarding selects. It sits beside the control unit, between the Fetch/Decode and Decode/Execute pipeline registers, and generalises the pipeline to any register count, stage depth and load latency.

## Interface
- NUM_REGS, 16, architectural register count
- REG_AW, $clog2(NUM_REGS), register address width
- DEPTH, 3, tracked stages after decode (index 0 = execute … DEPTH-1 = writeback)
- LOAD_AVAIL, 2, first stage index at which load data is forwardable (must be < DEPTH)
- CNT_W, 16, width of performance counters
- FW, $clog2(DEPTH+1), forward-select width
- clk  in  1  system clock; single clock domain, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- dec_valid  in  1  decode stage holds a valid instruction
- dec_rs1, dec_rs2  in  REG_AW  source registers (regfile a1, a2)
- dec_use_rs1, dec_use_rs2  in  1  source actually read
- dec_rd  in  REG_AW  destination register
- dec_we  in  1  instruction writes dec_rd
- dec_is_load  in  1  destination written from RAM
- branch_taken  in  1  execute-stage branch resolved taken (select_next_PC)
- stall_f  out  1  hold PC and Fetch/Decode register
- flush_d  out  1  clear Fetch/Decode register
- bubble_e  out  1  load a NOP into Decode/Execute register
- fwd_a, fwd_b  out  FW  0 = regfile, k = result of stage index k-1
- busy  out  NUM_REGS  bitmap of registers with pending writes
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

## Operation
- Scoreboard entry: {valid, rd, we, is_load}. Every cycle entries shift toward index DEPTH-1; oldest entry drops.
- issue = dec_valid & !stall_f & !branch_taken. Entry 0 receives decode fields when issue, else an invalid entry (bubble).
- Source match at index i: valid & we & rd == src & use_src.
- hazard = some used source's youngest (lowest-index) match is a load with i < LOAD_AVAIL.
- Branch priority: branch_taken -> flush_d=1, bubble_e=1, stall_f=0, regardless of hazard.
- Otherwise hazard & dec_valid -> stall_f=1, bubble_e=1, flush_d=0.
- Otherwise all three 0.
- fwd_x = i+1 for the youngest matching index i, else 0. Youngest match always wins, even if an older match exists. fwd_x is meaningful only when no stall is asserted.
- busy[r] = OR over entries of (valid & we & rd == r).
- stall_cnt increments on each cycle with stall_f=1; flush_cnt increments on each cycle with flush_d=1. Both saturate at 2^CNT_W-1 and never wrap.

## Timing
- stall_f, flush_d, bubble_e, fwd_a, fwd_b are combinational from scoreboard state and decode inputs, valid in the same cycle. busy and the counters are registered state.
- Scoreboard and counters update on the rising clk edge.
- Reset asserted (any time, including mid-stall): all entries invalid and counters 0 immediately. Outputs become stall_f=0, flush_d=0, bubble_e=0, fwd=0, busy=0.
- Load-use penalty = LOAD_AVAIL cycles when the dependent instruction immediately follows the load. With defaults this is 2 bubbles, then fwd=3 (writeback).
- ALU-to-ALU dependency: zero penalty, forwarded from execute (fwd=1).
- A writeback-stage match is forwarded (fwd=DEPTH). The bench must not rely on regfile write-before-read.

## Structure
- hazard_pkg: sb_entry_t struct, FWD_RF=0 constant, and a function to compute FW from DEPTH.
- One sub-module, src_forward_select, instantiated twice (rs1, rs2). It performs per-entry match, youngest-priority encode, load-availability check, and outputs fwd code plus hazard bit.
- Top level holds the shift register, issue/branch priority logic, busy OR-reduce and counters.

## Test plan
- Reset mid-operation: assert reset during a load-use stall -> stall_f=0, busy=0, counters=0 that cycle.
- Back-to-back RAW: issue rd=3 we=1, next decode rs1=3 -> fwd_a=1, stall_f=0. One cycle later with no new write to 3 -> fwd_a=2.
- Load-use: load rd=5, next decode rs2=5 -> stall_f=bubble_e=1 for 2 cycles, then fwd_b=3 with issue; stall_cnt=2.
- Youngest priority: rd=4 issued twice consecutively, then rs1=4 -> fwd_a=1, not 2.
- Branch vs stall: branch_taken=1 while a load-use hazard is present -> flush_d=1, bubble_e=1, stall_f=0; flush_cnt +1, stall_cnt unchanged.
- Saturation with CNT_W=4: hold the stall condition for 20 cycles -> stall_cnt stops at 15.
